// File: rtl/ysyx_22040632_ifu_axi_rd_bridge.sv
// Instruction-side AXI4 read bridge: one icache read request becomes one AR burst, R beats are streamed back.
// Optional error tracking (rresp/rid/beat-count/write-request) is enabled by defining YSYX_22040632_IAXI_ERR_EN.
module ysyx_22040632_ifu_axi_rd_bridge #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 64,
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic              clk,
  input  logic              rrst_n,
  input  logic              rw_valid,
  input  logic              rw_req,
  input  logic [ADDR_W-1:0] rw_addr,
  input  logic [7:0]        rw_len,
  input  logic [2:0]        rw_size,
  output logic              rw_ready,
  output logic [DATA_W-1:0] data_read,
  output logic              r_hs,
  output logic              r_last,
  output logic              rd_err,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [3:0]        rid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic              start;

  assign start = (state == S_IDLE) && rw_valid && !rw_req;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rw_ready  = 1'b0;
    r_hs      = 1'b0;
    r_last    = 1'b0;
    data_read = '0;
    unique case (state)
      S_IDLE: begin
        if (rw_valid) state_nxt = rw_req ? S_DONE : S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = S_R;
      end
      S_R: begin
        rready    = 1'b1;
        r_hs      = rvalid;
        r_last    = rvalid && rlast;
        data_read = rdata;
        if (rvalid && rlast) state_nxt = S_DONE;
      end
      S_DONE: begin
        rw_ready  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request fields are captured once in IDLE; later changes on rw_* are ignored.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
    end else if (start) begin
      addr_q <= rw_addr;
      len_q  <= rw_len;
      size_q <= rw_size;
    end
  end

  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arid    = AXI_ID;
  assign arburst = 2'b01;

`ifdef YSYX_22040632_IAXI_ERR_EN
  logic [7:0] beat_cnt;
  logic       rd_err_q;
  logic       beat_bad;

  // A beat is flagged on a bad response, foreign ID, or RLAST at the wrong count.
  assign beat_bad = (rresp != 2'b00) || (rid != AXI_ID) || (rlast && (beat_cnt != len_q));

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      beat_cnt <= '0;
      rd_err_q <= 1'b0;
    end else begin
      if (start)     beat_cnt <= '0;
      else if (r_hs) beat_cnt <= beat_cnt + 8'd1;
      if ((state == S_IDLE && rw_valid && rw_req) || (r_hs && beat_bad))
        rd_err_q <= 1'b1;
    end
  end

  assign rd_err = rd_err_q;
`else
  logic unused_err;
  assign unused_err = ^{rresp, rid};
  assign rd_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22040632_ifu_axi_rd_bridge.sv
// Self-checking bench for the IFU AXI read bridge: directed scenarios plus randomized bursts
// against a transaction-level model of the expected AXI and requester-side behaviour.
module tb_ysyx_22040632_ifu_axi_rd_bridge;

  logic        clk;
  logic        rrst_n;
  logic        rw_valid;
  logic        rw_req;
  logic [31:0] rw_addr;
  logic [7:0]  rw_len;
  logic [2:0]  rw_size;
  logic        rw_ready;
  logic [63:0] data_read;
  logic        r_hs;
  logic        r_last;
  logic        rd_err;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  ysyx_22040632_ifu_axi_rd_bridge dut (
    .clk(clk), .rrst_n(rrst_n),
    .rw_valid(rw_valid), .rw_req(rw_req), .rw_addr(rw_addr), .rw_len(rw_len), .rw_size(rw_size),
    .rw_ready(rw_ready), .data_read(data_read), .r_hs(r_hs), .r_last(r_last), .rd_err(rd_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   done_cyc = -100;
  logic exp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, arvalid, 0);
    check({tag, "_rready"}, rready, 0);
    check({tag, "_rw_ready"}, rw_ready, 0);
    check({tag, "_r_hs"}, r_hs, 0);
    check({tag, "_r_last"}, r_last, 0);
    check({tag, "_data_read"}, data_read, 0);
    check({tag, "_rd_err"}, rd_err, 0);
    check({tag, "_araddr"}, araddr, 0);
    check({tag, "_arlen"}, arlen, 0);
    check({tag, "_arsize"}, arsize, 0);
    check({tag, "_arid"}, arid, 4'h0);
    check({tag, "_arburst"}, arburst, 2'b01);
  endtask

  // One read request seen from both sides: requester at T0, AXI slave answering with
  // ar_dly stall cycles, per-beat gaps in [gap_min,gap_max], RLAST on beat last_idx,
  // SLVERR on beat bad_beat, and an asynchronous reset right after beat abort_at.
  task automatic run_txn(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input int ar_dly, input int gap_min, input int gap_max,
                         input int last_idx, input int bad_beat, input int abort_at,
                         input bit chk_b2b);
    logic [63:0] d;
    int          g;
    rw_valid = 1'b1; rw_req = 1'b0; rw_addr = addr; rw_len = len; rw_size = size;
    #1;
    check("t0_arvalid", arvalid, 0);
    tick();
    if (chk_b2b) check("b2b_latency", 64'(cyc - done_cyc), 2);
    rw_addr = $urandom; rw_len = 8'($urandom); rw_size = 3'($urandom);
    for (int i = 0; i <= ar_dly; i++) begin
      arready = (i == ar_dly);
      rvalid  = (i != ar_dly);
      rlast   = 1'b1;
      rdata   = {$urandom, $urandom};
      #1;
      check("ar_valid", arvalid, 1);
      check("ar_addr", araddr, addr);
      check("ar_len", arlen, len);
      check("ar_size", arsize, size);
      check("ar_burst", arburst, 2'b01);
      check("ar_id", arid, 4'h0);
      check("ar_rready", rready, 0);
      check("stray_r_hs", r_hs, 0);
      check("stray_data", data_read, 0);
      tick();
    end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    for (int b = 0; b <= last_idx; b++) begin
      g = $urandom_range(gap_max, gap_min);
      for (int j = 0; j < g; j++) begin
        rvalid = 1'b0;
        rdata  = {$urandom, $urandom};
        #1;
        check("gap_rready", rready, 1);
        check("gap_r_hs", r_hs, 0);
        check("gap_rw_ready", rw_ready, 0);
        tick();
      end
      d = {$urandom, $urandom};
      rvalid = 1'b1; rdata = d; rlast = (b == last_idx);
      rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
      #1;
      check("beat_r_hs", r_hs, 1);
      check("beat_data", data_read, d);
      check("beat_r_last", r_last, (b == last_idx));
      check("beat_rw_ready", rw_ready, 0);
      check("beat_arvalid", arvalid, 0);
`ifdef YSYX_22040632_IAXI_ERR_EN
      if (b == bad_beat) exp_err = 1'b1;
      if (b == last_idx && last_idx != int'(len)) exp_err = 1'b1;
`endif
      if (b == abort_at) begin
        rrst_n = 1'b0;
        exp_err = 1'b0;
        #1;
        check_reset_outputs("abort");
        rw_valid = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        tick();
        check_reset_outputs("abort_hold");
        rrst_n = 1'b1;
        #1;
        check("post_abort_rw_ready", rw_ready, 0);
        return;
      end
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    #1;
    check("done_rw_ready", rw_ready, 1);
    check("done_rready", rready, 0);
    check("done_r_hs", r_hs, 0);
    check("done_data", data_read, 0);
    done_cyc = cyc;
    rw_valid = 1'b0;
    tick();
    check("idle_rw_ready", rw_ready, 0);
    check("idle_arvalid", arvalid, 0);
    check("idle_rd_err", rd_err, exp_err);
  endtask

  task automatic run_write();
    rw_valid = 1'b1; rw_req = 1'b1; rw_addr = $urandom;
    #1;
    check("wr_t0_arvalid", arvalid, 0);
    tick();
    check("wr_rw_ready", rw_ready, 1);
    check("wr_arvalid", arvalid, 0);
`ifdef YSYX_22040632_IAXI_ERR_EN
    exp_err = 1'b1;
`endif
    rw_valid = 1'b0; rw_req = 1'b0;
    tick();
    check("wr_idle_rw_ready", rw_ready, 0);
    check("wr_idle_arvalid", arvalid, 0);
    check("wr_rd_err", rd_err, exp_err);
  endtask

  initial begin
    logic [7:0] len;
    rrst_n = 1'b0; rw_valid = 1'b0; rw_req = 1'b0; rw_addr = '0; rw_len = '0; rw_size = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 4'h0;
    #3;
    check_reset_outputs("por");
    tick();
    tick();
    rrst_n = 1'b1;
    tick();
    check_reset_outputs("post_por");

    // Line fill, immediate arready, back-to-back beats.
    run_txn(32'h8000_0040, 8'd7, 3'd3, 0, 0, 0, 7, -1, -1, 1'b0);
    tick();
    // Uncacheable single beat with arready delayed 3 cycles.
    run_txn(32'h8000_0004, 8'd0, 3'd2, 3, 0, 0, 0, -1, -1, 1'b0);
    check("unc_rd_err", rd_err, 0);
    tick();
    // Gapped R: two idle cycles before every beat.
    run_txn(32'h8000_0080, 8'd7, 3'd3, 1, 2, 2, 7, -1, -1, 1'b0);
    // Back-to-back: next request raised in the cycle right after DONE.
    run_txn(32'h8000_00c0, 8'd7, 3'd3, 0, 0, 1, 7, -1, -1, 1'b1);
    run_txn(32'h8000_0100, 8'd0, 3'd3, 0, 0, 0, 0, -1, -1, 1'b1);
    tick();
    // Error scenario: SLVERR on beat 3 and RLAST on beat 6 of an 8-beat burst.
    run_txn(32'h8000_0140, 8'd7, 3'd3, 0, 0, 1, 5, 2, -1, 1'b0);
    tick();
    check("err_sticky", rd_err, exp_err);
    run_write();

    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(2, 0))
        0:       len = 8'd0;
        1:       len = 8'd7;
        default: len = 8'($urandom_range(15, 1));
      endcase
      run_txn({4'h8, 22'($urandom), 6'h0}, len, 3'($urandom_range(3, 2)),
              $urandom_range(3, 0), 0, $urandom_range(2, 0), int'(len),
              $urandom_range(20, 0), -1, 1'b0);
      if ($urandom_range(1, 0) == 1) tick();
    end

    // Reset after beat 4 of a fill, then a fresh request.
    run_txn(32'h8000_0200, 8'd7, 3'd3, 0, 0, 0, 7, -1, 3, 1'b0);
    tick();
    run_txn(32'h8000_0240, 8'd7, 3'd3, 1, 0, 1, 7, -1, -1, 1'b0);
    check("final_rd_err", rd_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
